// File: rtl/seq_multiplier_32bit_pkg.sv
// Shared types and constants for the 32x32 shift-add sequential multiplier.
// Also holds the operand-magnitude helper used at request acceptance.
package seq_multiplier_32bit_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned ITERATIONS = 32;
   localparam int unsigned CNT_W      = $clog2(ITERATIONS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_e;

   // Two's-complement -2^31 maps onto itself, which read as unsigned is exactly 2^31.
   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] value,
                                                   input logic              is_signed);
      logic [DATA_W-1:0] result;
      result = value;
      if (is_signed && value[DATA_W-1]) begin
         result = ~value + DATA_W'(1);
      end
      return result;
   endfunction

endpackage

// File: rtl/seq_multiplier_32bit_adder_33bit.sv
// Partial-product adder for one shift-add step: two 32-bit magnitudes summed
// into a 33-bit result so the carry can be shifted back into the accumulator.
module adder_33bit
   import seq_multiplier_32bit_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W:0]   sum_o
);

   assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/seq_multiplier_32bit.sv
// 32x32 sequential multiplier: one shift-add step per cycle on operand magnitudes,
// sign applied to the 64-bit result on the final step.
module seq_multiplier_32bit
   import seq_multiplier_32bit_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              is_signed,
   input  logic [DATA_W-1:0] operand_a,
   input  logic [DATA_W-1:0] operand_b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product_hi,
   output logic [DATA_W-1:0] product_lo
);

   state_e                state_q, state_d;
   logic [2*DATA_W-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0]     mcand_q, mcand_d;
   logic                  sign_q, sign_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2*DATA_W-1:0]   prod_q, prod_d;

   logic [DATA_W:0]       partial_sum;
   logic [2*DATA_W-1:0]   acc_step;
   logic                  last_step;

   adder_33bit u_adder (
      .a_i   (acc_q[2*DATA_W-1:DATA_W]),
      .b_i   (acc_q[0] ? mcand_q : '0),
      .sum_o (partial_sum)
   );

   // The multiplier rides in the low half and is consumed LSB-first as the sum shifts in.
   assign acc_step  = {partial_sum, acc_q[DATA_W-1:1]};
   assign last_step = (cnt_q == CNT_W'(ITERATIONS - 1));

   // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      sign_d  = sign_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;

      case (state_q)
         IDLE, FINISH: begin
            state_d = IDLE;
            if (start) begin
               state_d = RUN;
               mcand_d = magnitude(operand_a, is_signed);
               acc_d   = {{DATA_W{1'b0}}, magnitude(operand_b, is_signed)};
               sign_d  = is_signed & (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]);
               cnt_d   = '0;
            end
         end
         RUN: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) begin
               state_d = FINISH;
               prod_d  = sign_q ? (~acc_step + 64'd1) : acc_step;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         sign_q  <= 1'b0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         sign_q  <= sign_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

   assign busy       = (state_q == RUN);
   assign done       = (state_q == FINISH);
   assign product_hi = prod_q[2*DATA_W-1:DATA_W];
   assign product_lo = prod_q[DATA_W-1:0];

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Directed and randomized checks of seq_multiplier_32bit against an arithmetic
// reference product, including latency, busy width, ignored starts and reset abort.
module tb_seq_multiplier_32bit;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        done;
   logic [31:0] product_hi;
   logic [31:0] product_lo;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   seq_multiplier_32bit dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .is_signed  (is_signed),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .busy       (busy),
      .done       (done),
      .product_hi (product_hi),
      .product_lo (product_lo)
   );

   function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                               input logic s);
      longint          sa, sb;
      longint unsigned ua, ub;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      ua = longint'(a);
      ub = longint'(b);
      return ua * ub;
   endfunction

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
      operand_a = a;
      operand_b = b;
      is_signed = s;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   // Edges are counted from the accepting edge; done must appear on the 32nd edge after it.
   task automatic wait_result(input string tag, input logic [63:0] expected, input int intrude_at);
      int          edges;
      int          busy_cnt;
      bit          stable;
      logic [63:0] held;
      edges    = 0;
      busy_cnt = 0;
      stable   = 1'b1;
      held     = {product_hi, product_lo};
      while (done !== 1'b1 && edges < 100) begin
         if (busy === 1'b1) busy_cnt++;
         if ({product_hi, product_lo} !== held) stable = 1'b0;
         if (intrude_at != 0 && edges == intrude_at) begin
            start     = 1'b1;
            operand_a = $urandom;
            operand_b = $urandom;
            is_signed = ~is_signed;
         end else begin
            start = 1'b0;
         end
         @(posedge clock);
         edges++;
         @(negedge clock);
      end
      start = 1'b0;
      check({tag, " latency"}, 64'(edges), 64'd32);
      check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
      check({tag, " held_in_run"}, 64'(stable), 64'd1);
      check({tag, " busy_at_done"}, 64'(busy), 64'd0);
      check({tag, " product"}, {product_hi, product_lo}, expected);
   endtask

   initial begin
      int          done_seen;
      logic [31:0] ra, rb;
      logic        rs;

      reset     = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      operand_a = '0;
      operand_b = '0;
      tick();
      tick();
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset product", {product_hi, product_lo}, 64'd0);
      reset = 1'b0;
      tick();

      start_op(32'd3, 32'd5, 1'b0);
      wait_result("u3x5", 64'h00000000_0000000F, 0);
      tick();
      check("u3x5 done_width", 64'(done), 64'd0);
      check("u3x5 idle_hold", {product_hi, product_lo}, 64'h0000000F);

      start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      wait_result("umax", 64'hFFFFFFFE_00000001, 0);
      tick();

      start_op(32'hFFFF_FFF9, 32'd3, 1'b1);
      wait_result("s-7x3", 64'hFFFFFFFF_FFFFFFEB, 0);
      tick();

      start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
      wait_result("sminxmin", 64'h40000000_00000000, 0);
      tick();

      start_op(32'hFFFF_FFF9, 32'd0, 1'b1);
      wait_result("s-7x0", 64'd0, 0);
      tick();

      start_op(32'h0001_2345, 32'h0006_789A, 1'b0);
      wait_result("ignored_start", ref_product(32'h0001_2345, 32'h0006_789A, 1'b0), 9);
      tick();

      start_op(32'h0000_DEAD, 32'hFFFF_BEEF, 1'b1);
      repeat (19) tick();
      check("abort busy_before", 64'(busy), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      check("abort product", {product_hi, product_lo}, 64'd0);
      done_seen = 0;
      repeat (40) begin
         if (done === 1'b1) done_seen++;
         tick();
      end
      check("abort no_done", 64'(done_seen), 64'd0);
      start_op(32'd2, 32'd2, 1'b0);
      wait_result("after_reset 2x2", 64'd4, 0);
      tick();

      start_op(32'd9, 32'd11, 1'b0);
      wait_result("b2b first", 64'd99, 0);
      start_op(32'd6, 32'd7, 1'b0);
      check("b2b busy_now", 64'(busy), 64'd1);
      wait_result("b2b second", 64'h2A, 0);
      tick();

      for (int i = 0; i < 10; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         if (i == 3) ra = 32'h8000_0000;
         start_op(ra, rb, rs);
         wait_result($sformatf("rand%0d", i), ref_product(ra, rb, rs), 0);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
